// File: rtl/pc_pkg.sv
// Shared constants for the fetch-PC sequencer: default vectors, address width,
// alignment/increment defaults, and a parameter legality helper.
package pc_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_2000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_2100;
  localparam int          ALIGN_BYTES_DEF  = 4;
  localparam int          INC_BYTES_DEF    = 4;
  localparam int          NUM_REDIRECT_DEF = 2;
  localparam int          STAGES_DEF       = 3;
  localparam int          CNT_W_DEF        = 16;

  function automatic bit align_legal(input int align_bytes);
    return (align_bytes == 2) || (align_bytes == 4);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of control inputs and PC/status outputs between the resolution logic
// and the fetch-PC sequencer.
interface pc_sequencer_if #(
  parameter int XLEN         = 32,
  parameter int NUM_REDIRECT = 2,
  parameter int STAGES       = 3,
  parameter int CNT_W        = 16
);
  // redirect_valid is a request without backpressure: any set bit is consumed
  // on the very next rising edge, there is no ready signal.
  logic                         stall;
  logic [NUM_REDIRECT-1:0]      redirect_valid;
  logic [NUM_REDIRECT*XLEN-1:0] redirect_target;
  logic [XLEN-1:0]              next_pc;
  logic [XLEN-1:0]              fetch_pc;
  logic                         fetch_valid;
  logic [STAGES*XLEN-1:0]       stage_pc;
  logic [STAGES-1:0]            stage_valid;
  logic                         misalign_fault;
  logic [XLEN-1:0]              fault_addr;
  logic [CNT_W-1:0]             redirect_count;

  modport master (
    output stall, redirect_valid, redirect_target,
    input  next_pc, fetch_pc, fetch_valid, stage_pc, stage_valid,
           misalign_fault, fault_addr, redirect_count
  );

  modport slave (
    input  stall, redirect_valid, redirect_target,
    output next_pc, fetch_pc, fetch_valid, stage_pc, stage_valid,
           misalign_fault, fault_addr, redirect_count
  );
endinterface

// File: rtl/redirect_arbiter.sv
// Fixed-priority selection among redirect channels; channel 0 wins.
module redirect_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_REDIRECT = 2
) (
  input  logic [NUM_REDIRECT-1:0]      valid_i,
  input  logic [NUM_REDIRECT*XLEN-1:0] target_i,
  output logic                         any_valid_o,
  output logic [XLEN-1:0]              target_o
);

  // Scan from the lowest priority up so the lowest set index is written last.
  always_comb begin
    any_valid_o = 1'b0;
    target_o    = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        any_valid_o = 1'b1;
        target_o    = target_i[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC generator: holds the fetch PC, picks the next PC from redirects,
// stall or increment, traps misaligned targets and tracks in-flight stage PCs.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF,
  parameter int              NUM_REDIRECT = NUM_REDIRECT_DEF,
  parameter int              STAGES       = STAGES_DEF,
  parameter int              ALIGN_BYTES  = ALIGN_BYTES_DEF,
  parameter int              INC_BYTES    = INC_BYTES_DEF,
  parameter int              CNT_W        = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  if (!align_legal(ALIGN_BYTES) || STAGES < 1 || NUM_REDIRECT < 1) begin : g_param_check
    $error("pc_sequencer: illegal ALIGN_BYTES/STAGES/NUM_REDIRECT");
  end

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN_BYTES - 1);
  localparam logic [XLEN-1:0] INC        = XLEN'(INC_BYTES);

  logic            any_valid;
  logic [XLEN-1:0] win_target;
  logic            win_misaligned;

  redirect_arbiter #(.XLEN(XLEN), .NUM_REDIRECT(NUM_REDIRECT)) u_arb (
    .valid_i     (bus.redirect_valid),
    .target_i    (bus.redirect_target),
    .any_valid_o (any_valid),
    .target_o    (win_target)
  );

  assign win_misaligned = (win_target & ALIGN_MASK) != '0;

  logic [XLEN-1:0]              fetch_pc_q, fetch_pc_d;
  logic                         fetch_valid_q;
  logic [STAGES-1:0][XLEN-1:0]  stage_pc_q, stage_pc_d;
  logic [STAGES-1:0]            stage_valid_q, stage_valid_d;
  logic                         fault_q, fault_d;
  logic [XLEN-1:0]              fault_addr_q, fault_addr_d;
  logic [CNT_W-1:0]             count_q, count_d;

  always_comb begin
    fetch_pc_d = fetch_pc_q + INC;
    if (reset) begin
      fetch_pc_d = RESET_VECTOR;
    end else if (any_valid) begin
      fetch_pc_d = win_misaligned ? TRAP_VECTOR : win_target;
    end else if (bus.stall) begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // A redirect squashes every tracked stage; stage PCs are left as they were.
  always_comb begin
    stage_pc_d    = stage_pc_q;
    stage_valid_d = stage_valid_q;
    if (any_valid) begin
      stage_valid_d = '0;
    end else if (!bus.stall) begin
      stage_pc_d[0]    = fetch_pc_q;
      stage_valid_d[0] = fetch_valid_q;
      for (int i = 1; i < STAGES; i++) begin
        stage_pc_d[i]    = stage_pc_q[i-1];
        stage_valid_d[i] = stage_valid_q[i-1];
      end
    end
  end

  always_comb begin
    fault_d      = any_valid && win_misaligned;
    fault_addr_d = fault_d ? win_target : fault_addr_q;
    count_d      = count_q;
    if (any_valid && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      stage_pc_q    <= '0;
      stage_valid_q <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= 1'b1;
      stage_pc_q    <= stage_pc_d;
      stage_valid_q <= stage_valid_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      count_q       <= count_d;
    end
  end

  assign bus.next_pc        = fetch_pc_d;
  assign bus.fetch_pc       = fetch_pc_q;
  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.stage_pc       = stage_pc_q;
  assign bus.stage_valid    = stage_valid_q;
  assign bus.misalign_fault = fault_q;
  assign bus.fault_addr     = fault_addr_q;
  assign bus.redirect_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random stimulus for pc_sequencer against a small cycle model,
// with expected fetch PCs passed through a scoreboard queue.
module tb_pc_sequencer;

  localparam logic [31:0] RST_VEC  = 32'h0000_2000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_2100;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] exp_q[$];

  logic [31:0] m_pc;
  logic        m_fv;
  logic [31:0] m_spc [3];
  logic [2:0]  m_sv;
  logic        m_flt;
  logic [31:0] m_faddr;
  logic [1:0]  m_cnt;

  pc_sequencer_if #(.XLEN(32), .NUM_REDIRECT(2), .STAGES(3), .CNT_W(2)) bus ();

  pc_sequencer #(
    .XLEN(32), .RESET_VECTOR(RST_VEC), .TRAP_VECTOR(TRAP_VEC), .NUM_REDIRECT(2),
    .STAGES(3), .ALIGN_BYTES(4), .INC_BYTES(4), .CNT_W(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_VEC; m_fv = 1'b0; m_sv = 3'b000; m_flt = 1'b0; m_faddr = '0; m_cnt = '0;
    for (int i = 0; i < 3; i++) m_spc[i] = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".next_pc"}, bus.next_pc, RST_VEC);
    chk({tag, ".fetch_pc"}, bus.fetch_pc, RST_VEC);
    chk({tag, ".fetch_valid"}, 32'(bus.fetch_valid), 32'd0);
    chk({tag, ".stage_valid"}, 32'(bus.stage_valid), 32'd0);
    chk({tag, ".stage_pc_lo"}, bus.stage_pc[31:0], 32'd0);
    chk({tag, ".stage_pc_hi"}, bus.stage_pc[95:64], 32'd0);
    chk({tag, ".fault"}, 32'(bus.misalign_fault), 32'd0);
    chk({tag, ".fault_addr"}, bus.fault_addr, 32'd0);
    chk({tag, ".count"}, 32'(bus.redirect_count), 32'd0);
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input logic st, input logic [1:0] rv, input logic [31:0] t0,
                      input logic [31:0] t1);
    logic [31:0] w, npc;
    logic        redir, mis;
    bus.stall = st; bus.redirect_valid = rv; bus.redirect_target = {t1, t0};
    redir = |rv;
    w     = rv[0] ? t0 : t1;
    mis   = (w[1:0] != 2'b00);
    npc   = redir ? (mis ? TRAP_VEC : w) : (st ? m_pc : m_pc + 32'd4);
    #1;
    chk("next_pc", bus.next_pc, npc);
    exp_q.push_back(npc);
    @(posedge clk);
    if (redir) begin
      m_sv = 3'b000;
    end else if (!st) begin
      m_spc[2] = m_spc[1]; m_spc[1] = m_spc[0]; m_spc[0] = m_pc;
      m_sv = {m_sv[1:0], m_fv};
    end
    m_flt = redir && mis;
    if (m_flt) m_faddr = w;
    if (redir && m_cnt != 2'b11) m_cnt = m_cnt + 2'd1;
    m_fv = 1'b1;
    m_pc = npc;
    #1;
    chk("fetch_pc", bus.fetch_pc, exp_q.pop_front());
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_fv));
    chk("stage_valid", 32'(bus.stage_valid), 32'(m_sv));
    for (int i = 0; i < 3; i++) begin
      if (m_sv[i]) chk($sformatf("stage_pc[%0d]", i), bus.stage_pc[i*32 +: 32], m_spc[i]);
    end
    chk("misalign_fault", 32'(bus.misalign_fault), 32'(m_flt));
    chk("fault_addr", bus.fault_addr, m_faddr);
    chk("redirect_count", 32'(bus.redirect_count), 32'(m_cnt));
  endtask

  initial begin
    logic [1:0]  cnt_seq [5];
    logic [1:0]  rv;
    logic [31:0] t0, t1;
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    reset = 1'b1;
    bus.stall = 1'b0; bus.redirect_valid = '0; bus.redirect_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("por");

    // Sequential fetch from the reset vector.
    reset = 1'b0;
    step(1'b0, 2'b00, 32'h0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    chk("seq_pc_2008", bus.fetch_pc, 32'h0000_2008);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0);

    // Stall holds PC and stage pipe.
    repeat (3) step(1'b1, 2'b00, 32'h0, 32'h0);
    chk("stall_pc_hold", bus.fetch_pc, 32'h0000_2010);

    // Both channels with stall: channel 0 wins, pipe squashed.
    step(1'b1, 2'b11, 32'h0000_3000, 32'h0000_4000);
    chk("prio_ch0", bus.fetch_pc, 32'h0000_3000);
    repeat (4) step(1'b0, 2'b00, 32'h0, 32'h0);

    // Misaligned winner traps; lower channel ignored.
    step(1'b0, 2'b11, 32'h0000_3002, 32'h0000_5000);
    chk("trap_pc", bus.fetch_pc, TRAP_VEC);
    chk("trap_addr", bus.fault_addr, 32'h0000_3002);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    chk("fault_one_cycle", 32'(bus.misalign_fault), 32'd0);

    // Channel 1 alone, misaligned by 1; then aligned ch0 over misaligned ch1.
    step(1'b0, 2'b10, 32'h0, 32'h0000_4001);
    step(1'b0, 2'b11, 32'h0000_6000, 32'h0000_4002);
    chk("fault_addr_held", bus.fault_addr, 32'h0000_4001);

    // Wrap at the top of the address space.
    step(1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0);
    step(1'b0, 2'b00, 32'h0, 32'h0);
    chk("wrap_pc", bus.fetch_pc, 32'h0000_0000);

    // Reset mid-stall with a redirect pending clears everything at once.
    bus.stall = 1'b1; bus.redirect_valid = 2'b01; bus.redirect_target = {32'h0, 32'h0000_5000};
    #1 reset = 1'b1;
    #1 chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1 chk("mid_reset_hold", bus.fetch_pc, RST_VEC);
    bus.stall = 1'b0; bus.redirect_valid = '0; bus.redirect_target = '0;
    model_reset();
    reset = 1'b0;

    // Saturating counter: 1,2,3,3,3.
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'b01, 32'h0000_7000 + 32'(k * 16), 32'h0);
      chk($sformatf("count_seq[%0d]", k), 32'(bus.redirect_count), 32'(cnt_seq[k]));
    end

    // Random mix; counter model restarts from a fresh reset.
    reset = 1'b1;
    #1 model_reset();
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t0 = 32'h0000_8000 + 32'($urandom_range(0, 63) * 2);
      t1 = 32'h0000_9000 + 32'($urandom_range(0, 63) * 4);
      step(1'($urandom_range(0, 1)), rv, t0, t1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
